// File: rtl/jump_scanner.sv
// Bracket matcher: walks program memory from a '[' or ']' to its partner, tracking nesting depth.
// One instruction per 3 cycles (STEP/FETCH/EVAL); reports matching address or error with a one-cycle done pulse.
module jump_scanner #(
  parameter int PC_W = 10,
  parameter int BC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dir,
  input  logic [PC_W-1:0] start_pc,
  input  logic [PC_W-1:0] prog_len,
  input  logic [2:0]      cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] target_pc
);

  typedef enum logic [2:0] {IDLE, STEP, FETCH, EVAL, FIN} state_t;

  localparam logic [2:0]      CMD_OPEN  = 3'b100;
  localparam logic [2:0]      CMD_CLOSE = 3'b101;
  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0] BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [BC_W-1:0] depth, depth_n;
  logic            err_flag, err_flag_n;
  logic            dir_q, dir_n;
  logic [PC_W-1:0] target_n;
  logic            at_end;
  logic [2:0]      nest_cmd, unnest_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      depth     <= '0;
      err_flag  <= 1'b0;
      dir_q     <= 1'b0;
      target_pc <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      depth     <= depth_n;
      err_flag  <= err_flag_n;
      dir_q     <= dir_n;
      target_pc <= target_n;
    end
  end

  // Extended-width compare so pc = all-ones cannot wrap past prog_len.
  assign at_end = dir_q ? (pc == '0)
                        : (({1'b0, pc} + {{PC_W{1'b0}}, 1'b1}) >= {1'b0, prog_len});

  // Backward scans treat ']' as nesting and '[' as the partner.
  assign nest_cmd   = dir_q ? CMD_CLOSE : CMD_OPEN;
  assign unnest_cmd = dir_q ? CMD_OPEN  : CMD_CLOSE;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    depth_n    = depth;
    err_flag_n = err_flag;
    dir_n      = dir_q;
    target_n   = target_pc;
    case (state)
      IDLE: begin
        if (start) begin
          dir_n      = dir;
          pc_n       = start_pc;
          depth_n    = '0;
          err_flag_n = 1'b0;
          state_n    = STEP;
        end
      end
      STEP: begin
        if (at_end) begin
          err_flag_n = 1'b1;
          target_n   = pc;
          state_n    = FIN;
        end else begin
          pc_n    = dir_q ? (pc - PC_ONE) : (pc + PC_ONE);
          state_n = FETCH;
        end
      end
      FETCH: state_n = EVAL;
      EVAL: begin
        state_n = STEP;
        if (cmd == nest_cmd) begin
          if (depth == '1) begin
            err_flag_n = 1'b1;
            target_n   = pc;
            state_n    = FIN;
          end else begin
            depth_n = depth + BC_ONE;
          end
        end else if (cmd == unnest_cmd) begin
          if (depth == '0) begin
            err_flag_n = 1'b0;
            target_n   = pc;
            state_n    = FIN;
          end else begin
            depth_n = depth - BC_ONE;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign mem_rd   = (state == FETCH);
  assign busy     = (state == STEP) || (state == FETCH) || (state == EVAL);
  assign done     = (state == FIN);
  assign err      = (state == FIN) && err_flag;

endmodule

// File: tb/tb_jump_scanner.sv
// Scoreboard bench for jump_scanner: expected (err, target, done cycle) queued at start, checked on done.
module tb_jump_scanner;
  localparam int PC_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start0, start1, dir;
  logic [PC_W-1:0] start_pc, prog_len;
  logic [2:0]      cmd0, cmd1;
  logic [PC_W-1:0] mem_addr0, mem_addr1, target_pc0, target_pc1;
  logic            mem_rd0, mem_rd1, busy0, busy1, done0, done1, err0, err1;

  logic [2:0] mem [0:(1<<PC_W)-1];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    bit sel;
    bit err;
    int tgt;
    int done_cyc;
  } exp_t;
  exp_t sb_q[$];

  jump_scanner #(.PC_W(PC_W), .BC_W(8)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .dir(dir), .start_pc(start_pc),
    .prog_len(prog_len), .cmd(cmd0), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
    .busy(busy0), .done(done0), .err(err0), .target_pc(target_pc0)
  );

  jump_scanner #(.PC_W(PC_W), .BC_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .dir(dir), .start_pc(start_pc),
    .prog_len(prog_len), .cmd(cmd1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .busy(busy1), .done(done1), .err(err1), .target_pc(target_pc1)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd0) cmd0 <= mem[mem_addr0];
    if (mem_rd1) cmd1 <= mem[mem_addr1];
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0 || done1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("done_sel", int'(done1), int'(e.sel));
        check_eq("done_cyc", cyc, e.done_cyc);
        check_eq("err", e.sel ? int'(err1) : int'(err0), int'(e.err));
        check_eq("target_pc", e.sel ? int'(target_pc1) : int'(target_pc0), e.tgt);
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = 3'b010;
    for (int i = 0; i < s.len(); i++) begin
      case (s.getc(i))
        "<":     mem[i] = 3'b000;
        ">":     mem[i] = 3'b001;
        "+":     mem[i] = 3'b010;
        "-":     mem[i] = 3'b011;
        "[":     mem[i] = 3'b100;
        "]":     mem[i] = 3'b101;
        ".":     mem[i] = 3'b110;
        default: mem[i] = 3'b111;
      endcase
    end
  endtask

  // lat is in cycles after the sampling edge, where the cycle just after that edge is 1.
  task automatic start_scan(input bit sel, input bit d, input int spc, input int plen,
                            input bit eerr, input int etgt, input int lat);
    @(negedge clk);
    dir      = d;
    start_pc = spc[PC_W-1:0];
    prog_len = plen[PC_W-1:0];
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{sel, eerr, etgt, cyc + lat - 1});
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, int'(busy0), 0);
    check_eq({tag, "_done"}, int'(done0), 0);
    check_eq({tag, "_err"}, int'(err0), 0);
    check_eq({tag, "_mem_rd"}, int'(mem_rd0), 0);
    check_eq({tag, "_mem_addr"}, int'(mem_addr0), 0);
    check_eq({tag, "_target_pc"}, int'(target_pc0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; dir = 1'b0;
    start_pc = '0; prog_len = '0;
    load("");
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // "[+]" with busy profile over cycles 1..7
    load("[+]");
    @(negedge clk);
    dir = 1'b0; start_pc = '0; prog_len = 10'd3; start0 = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{1'b0, 1'b0, 2, cyc + 6});
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      check_eq($sformatf("busy_c%0d", i), int'(busy0), (i <= 6) ? 1 : 0);
    end
    drain(50);

    load("[[-]>]");
    start_scan(0, 0, 0, 6, 0, 5, 16);
    drain(100);
    start_scan(0, 1, 5, 6, 0, 0, 16);
    drain(100);

    load("[+");
    start_scan(0, 0, 0, 2, 1, 1, 5);
    drain(50);
    load("+]");
    start_scan(0, 1, 1, 2, 1, 0, 5);
    drain(50);

    load("[[[]]]");
    start_scan(1, 0, 0, 6, 1, 2, 7);
    drain(50);

    // start pulsed mid-scan with other operands must not disturb or queue
    load("[[-]>]");
    start_scan(0, 0, 0, 6, 0, 5, 16);
    repeat (3) @(negedge clk);
    dir = 1'b1; start_pc = 10'd5; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; dir = 1'b0;
    drain(100);

    // reset during cycle 4 of a long scan abandons it
    load("[++++++++]");
    start_scan(0, 0, 0, 10, 0, 9, 28);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midreset");
    repeat (40) @(negedge clk);
    start_scan(0, 0, 0, 10, 0, 9, 28);
    drain(100);

    // reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; start0 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start0 = 1'b0;
    check_idle("rst_start");
    @(negedge clk);
    check_eq("rst_start_busy2", int'(busy0), 0);

    // start held high: back-to-back scans, next accepted in the IDLE cycle after FIN
    load("[+]");
    @(negedge clk);
    dir = 1'b0; start_pc = '0; prog_len = 10'd3; start0 = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    sb_q.push_back('{1'b0, 1'b0, 2, s + 6});
    sb_q.push_back('{1'b0, 1'b0, 2, s + 14});
    repeat (15) @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    drain(50);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_scanner.md
JUMP_SCANNER -- requirements
Module: jump_scanner

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, program-address width.
REQ-002 The block SHALL have parameter BC_W, default 8, bracket-nesting counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a scan; sampled only in IDLE.
REQ-006 dir  input  1  scan direction: 0 forward (from '['), 1 backward (from ']'); sampled with start.
REQ-007 start_pc  input  PC_W  address of the bracket that starts the scan; sampled with start.
REQ-008 prog_len  input  PC_W  count of valid program instructions; held stable during a scan.
REQ-009 cmd  input  3  program-memory read data, valid the cycle after mem_rd; encoding: < 000, > 001, + 010, - 011, [ 100, ] 101, . 110, , 111.
REQ-010 mem_addr  output  PC_W  program-memory read address.
REQ-011 mem_rd  output  1  program-memory read strobe.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  valid only while done=1; 1 = unmatched bracket or nesting overflow.
REQ-015 target_pc  output  PC_W  address of the matching bracket; on error, last address examined; held until the next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, STEP, FETCH, EVAL, FIN.
REQ-017 In IDLE, start=1 SHALL latch dir, set pc=start_pc and depth=0, and go to STEP; busy=0 in IDLE.
REQ-018 In STEP, forward with pc+1 >= prog_len, or backward with pc==0, SHALL set err_flag and go to FIN without changing pc.
REQ-019 Otherwise, in STEP, pc SHALL change to pc+1 (forward) or pc-1 (backward), then go to FETCH.
REQ-020 In FETCH, mem_rd=1 and mem_addr=pc, then go to EVAL.
REQ-021 In EVAL, forward: cmd=[ increments depth; cmd=] with depth=0 is a match; cmd=] with depth>0 decrements depth.
REQ-022 In EVAL, backward: the same rules apply with [ and ] swapped.
REQ-023 In EVAL, all other cmd values SHALL return to STEP with depth unchanged.
REQ-024 On a match, EVAL SHALL set target_pc=pc and err_flag=0, then go to FIN.
REQ-025 An increment with depth at its all-ones value SHALL set err_flag, set target_pc=pc, and go to FIN (no wrap).
REQ-026 On every exit to FIN from STEP on error, target_pc SHALL be set to pc.
REQ-027 In FIN, done=1 and err=err_flag for exactly one cycle, then go to IDLE.
REQ-028 Latency: a match k instructions from start_pc SHALL raise done exactly 3k+1 cycles after the start sampling edge.
REQ-029 Latency: an error after n addresses examined SHALL raise done exactly 3n+2 cycles after the start sampling edge.
REQ-030 start while busy or in FIN SHALL be ignored and not queued.
REQ-031 mem_rd SHALL be 0 in every state except FETCH.
REQ-032 mem_addr SHALL equal pc in all states.
REQ-033 Simultaneous start and reset: reset SHALL win.

Reset
REQ-034 reset=1 SHALL force IDLE on the next edge regardless of state, including mid-scan, and abandon the scan without a done pulse.
REQ-035 reset=1 SHALL set pc=0, depth=0, err_flag=0, target_pc=0.
REQ-036 The following cycle SHALL show busy=0, done=0, err=0, mem_rd=0, mem_addr=0, target_pc=0.

Verification
REQ-037 Memory "[+]", prog_len=3, start dir=0 start_pc=0 -> done at cycle 7, err=0, target_pc=2, busy high cycles 1-6.
REQ-038 Memory "[[-]>]", prog_len=6, dir=0 start_pc=0 -> target_pc=5, err=0, done at cycle 16; dir=1 start_pc=5 -> target_pc=0, err=0.
REQ-039 Memory "[+", prog_len=2, dir=0 start_pc=0 -> done at cycle 5, err=1, target_pc=1; memory "+]", dir=1 start_pc=1 -> err=1, target_pc=0.
REQ-040 BC_W=1, memory "[[[]]]", dir=0 start_pc=0 -> second inner '[' overflows: err=1, target_pc=2.
REQ-041 reset pulsed at cycle 4 of a long scan -> cycle 5 shows busy=0, mem_rd=0, no done pulse; a new start then completes correctly.
REQ-042 start held high throughout a scan -> exactly one done pulse per accepted start; a new scan is accepted the cycle after FIN.
